// File: rtl/sdram_phase_cal_if.sv
// sdram_phase_cal_if: CPU command, DQS sampler and DCM signals of the read-phase calibrator
interface sdram_phase_cal_if #(parameter int NLANES = 2);
  logic              pre_wcmd;
  logic [4:0]        wd;
  logic              enrd;
  logic [NLANES-1:0] dqsr90;
  logic [NLANES-1:0] dqsr270;
  logic              dcm_done;
  logic              dcm_rst;
  logic              dcm_en;
  logic              dcm_incdec;
  logic [1:0]        phase90sel;
  logic [1:0]        ph_err;
  logic [2*NLANES-1:0] lane_err;
  logic [7:0]        phase_cnt;
  logic              cal_busy;
  logic [1:0]        cal_stat;
  modport master (
    output pre_wcmd, wd, enrd, dqsr90, dqsr270, dcm_done,
    input  dcm_rst, dcm_en, dcm_incdec, phase90sel, ph_err, lane_err, phase_cnt, cal_busy, cal_stat
  );
  modport slave (
    input  pre_wcmd, wd, enrd, dqsr90, dqsr270, dcm_done,
    output dcm_rst, dcm_en, dcm_incdec, phase90sel, ph_err, lane_err, phase_cnt, cal_busy, cal_stat
  );
endinterface

// File: rtl/sdram_phase_cal.sv
// sdram_phase_cal: DQS read-phase monitor and DCM auto-calibrator; SDRAM_PHASE_AUTO90_EN adds a coarse-phase retry at the step limit
module sdram_phase_cal #(
  parameter int NLANES   = 2,
  parameter int NSAMP_W  = 6,
  parameter int SETTLE   = 16,
  parameter int STEP_LIM = 64,
  parameter int TMO_W    = 12
) (
  input logic sclk0,
  input logic rst,
  sdram_phase_cal_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MEAS, S_DECIDE, S_STEP, S_WAITD, S_SETL, S_LIMIT} state_t;
  localparam logic signed [7:0] LIM_P = 8'(STEP_LIM);
  localparam logic signed [7:0] LIM_N = 8'(-STEP_LIM);
  localparam logic [TMO_W-1:0] SET_END = TMO_W'(SETTLE - 1);
  state_t r_state, w_state_n;
  logic [NLANES-1:0] r_early, r_late;
  logic [NSAMP_W-1:0] r_smp;
  logic [TMO_W-1:0] r_tmo;
  logic signed [7:0] r_pc, w_pc_up, w_pc_dn;
  logic [1:0] r_p90, w_p90_n, r_stat, w_stat, r_rst_cnt;
  logic r_dcm_en, r_incdec, r_dir;
  logic w_man_dcm, w_man_step, w_man_rst, w_start, w_abort, w_step, w_clr, w_retry, w_stat_we, w_lim, w_all_edge, w_late_only;
`ifdef SDRAM_PHASE_AUTO90_EN
  logic r_lim_hit;
`endif
  assign w_man_dcm   = bus.pre_wcmd && bus.wd[1:0] != 2'd0;
  assign w_man_step  = w_man_dcm && bus.wd[1:0] != 2'd3;
  assign w_man_rst   = bus.pre_wcmd && bus.wd[1:0] == 2'd3;
  assign w_start     = bus.pre_wcmd && bus.wd[4] && r_state == S_IDLE;
  assign w_abort     = w_man_dcm && r_state != S_IDLE;
  assign w_all_edge  = &(r_early & r_late);
  assign w_late_only = |(r_late & ~r_early);
  assign w_lim       = r_pc >= LIM_P || r_pc <= LIM_N;
  assign w_clr       = bus.pre_wcmd || r_state == S_CLR || w_step;
  assign w_pc_up     = r_pc == 8'sh7f ? r_pc : r_pc + 8'sd1;
  assign w_pc_dn     = r_pc == 8'sh80 ? r_pc : r_pc - 8'sd1;
  assign w_p90_n     = !bus.pre_wcmd || bus.wd[3:2] == 2'd0 ? (w_retry ? (r_dir ? r_p90 + 2'd1 : r_p90 - 2'd1) : r_p90)
                     : bus.wd[3:2] == 2'd1 ? r_p90 + 2'd1 : bus.wd[3:2] == 2'd2 ? r_p90 - 2'd1 : 2'd0;
  // search state register; reset drops any search immediately
  always_ff @(posedge sclk0) r_state <= rst ? S_IDLE : w_state_n;
  // search sequencing: a manual DCM command always aborts, terminal results land in cal_stat on the way to IDLE
  always_comb begin
    w_state_n = r_state;
    w_step    = 1'b0;
    w_retry   = 1'b0;
    w_stat_we = 1'b0;
    w_stat    = 2'd0;
    if (w_abort) begin
      w_state_n = S_IDLE;
      w_stat_we = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          w_state_n = S_CLR;
          w_stat_we = 1'b1;
        end
        S_CLR: w_state_n = S_MEAS;
        S_MEAS: if (bus.enrd && &r_smp) w_state_n = S_DECIDE;
          else if (&r_tmo) begin
            w_state_n = S_IDLE;
            w_stat_we = 1'b1;
            w_stat    = 2'd3;
          end
        S_DECIDE: if (w_all_edge) begin
          w_state_n = S_IDLE;
          w_stat_we = 1'b1;
          w_stat    = 2'd1;
        end else w_state_n = w_lim ? S_LIMIT : S_STEP;
        S_STEP: begin
          w_step    = 1'b1;
          w_state_n = S_WAITD;
        end
        S_WAITD: if (bus.dcm_done) w_state_n = S_SETL;
          else if (&r_tmo) begin
            w_state_n = S_IDLE;
            w_stat_we = 1'b1;
            w_stat    = 2'd3;
          end
        S_SETL: if (r_tmo == SET_END) w_state_n = S_CLR;
`ifdef SDRAM_PHASE_AUTO90_EN
        S_LIMIT: if (r_lim_hit) begin
          w_state_n = S_IDLE;
          w_stat_we = 1'b1;
          w_stat    = 2'd2;
        end else begin
          w_retry   = 1'b1;
          w_state_n = S_CLR;
        end
`else
        S_LIMIT: begin
          w_state_n = S_IDLE;
          w_stat_we = 1'b1;
          w_stat    = 2'd2;
        end
`endif
        default: w_state_n = S_IDLE;
      endcase
    end
  end
`ifdef SDRAM_PHASE_AUTO90_EN
  // remembers a coarse-phase retry so a second limit in the same search fails
  always_ff @(posedge sclk0) r_lim_hit <= rst || w_start ? 1'b0 : w_retry ? 1'b1 : r_lim_hit;
`endif
  // sample counter for MEAS; shared timer restarts on every state change (MEAS/WAITD timeout, SETTLE delay)
  always_ff @(posedge sclk0) begin
    r_smp <= rst || r_state != S_MEAS ? '0 : r_smp + NSAMP_W'(bus.enrd);
    r_tmo <= rst || w_state_n != r_state ? '0 : r_tmo + 1'b1;
  end
  // sticky per-lane early/late flags; a clear beats a same-cycle set
  always_ff @(posedge sclk0)
    if (rst || w_clr) begin
      r_early <= '0;
      r_late  <= '0;
    end else if (bus.enrd) begin
      r_late  <= r_late | bus.dqsr90 | ~bus.dqsr270;
      r_early <= r_early | ~bus.dqsr90 | bus.dqsr270;
    end
  // DCM step/reset outputs, phase bookkeeping and search result
  always_ff @(posedge sclk0)
    if (rst) begin
      r_dcm_en  <= 1'b0;
      r_incdec  <= 1'b0;
      r_rst_cnt <= 2'd0;
      r_pc      <= 8'sd0;
      r_p90     <= 2'd0;
      r_dir     <= 1'b0;
      r_stat    <= 2'd0;
    end else begin
      r_dcm_en  <= w_man_step || w_step;
      r_incdec  <= w_man_step ? bus.wd[0] : w_step ? r_dir : r_incdec;
      r_rst_cnt <= w_man_rst || w_retry ? 2'd3 : r_rst_cnt != 2'd0 ? r_rst_cnt - 2'd1 : 2'd0;
      r_pc      <= w_man_rst || w_retry ? 8'sd0 : w_man_step ? (bus.wd[0] ? w_pc_up : w_pc_dn)
                 : w_step ? (r_dir ? w_pc_up : w_pc_dn) : r_pc;
      r_p90     <= w_p90_n;
      r_dir     <= r_state == S_DECIDE ? !w_late_only : r_dir;
      r_stat    <= w_stat_we ? w_stat : r_stat;
    end
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign bus.lane_err[2*i+1:2*i] = {r_early[i], r_late[i]};
  end
  assign bus.dcm_rst    = r_rst_cnt != 2'd0;
  assign bus.dcm_en     = r_dcm_en;
  assign bus.dcm_incdec = r_incdec;
  assign bus.phase90sel = r_p90;
  assign bus.ph_err     = {|r_early, |r_late};
  assign bus.phase_cnt  = r_pc;
  assign bus.cal_busy   = r_state != S_IDLE;
  assign bus.cal_stat   = r_stat;
endmodule

// File: tb/tb_sdram_phase_cal.sv
// tb_sdram_phase_cal: vector table for CPU commands, flag sequences, and DCM/DQS environment model for auto search
module tb_sdram_phase_cal;
  localparam int NL = 2;
  localparam int LIM = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sdram_phase_cal_if #(.NLANES(NL)) bus();
  sdram_phase_cal #(.NLANES(NL)) dut (.sclk0(clk), .rst(rst), .bus(bus.slave));
  int checks = 0, errors = 0;
  logic env_on = 1'b0, no_reads = 1'b0, hold_done = 1'b0;
  logic man_enrd = 1'b0, auto_enrd = 1'b0;
  logic [NL-1:0] man90 = '0, man270 = '0, auto90 = '0, auto270 = '0;
  int ph = 0, n_en = 0, done_cd = 0;
  int edge_pos [NL];
  assign bus.enrd    = env_on ? auto_enrd : man_enrd;
  assign bus.dqsr90  = env_on ? auto90 : man90;
  assign bus.dqsr270 = env_on ? auto270 : man270;

  typedef struct { logic [4:0] wd; logic en; logic inc; logic [7:0] pc; logic [1:0] p90; } vec_t;
  vec_t tv [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] w);
    bus.pre_wcmd = 1'b1;
    bus.wd = w;
    @(negedge clk);
    bus.pre_wcmd = 1'b0;
    bus.wd = 5'd0;
  endtask

  // DCM + DQS environment: true phase moves on each step, DQS seen early below the lane edge, late above, both on it
  initial begin
    bus.dcm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dcm_rst) ph = 0;
      bus.dcm_done = 1'b0;
      if (done_cd != 0) begin
        done_cd--;
        if (done_cd == 0) bus.dcm_done = 1'b1;
      end
      if (bus.dcm_en) begin
        ph += bus.dcm_incdec ? 1 : -1;
        n_en++;
        if (!hold_done) done_cd = $urandom_range(1, 5);
      end
      auto_enrd = !no_reads && ($urandom_range(0, 3) != 0);
      for (int l = 0; l < NL; l++) begin
        auto90[l]  = ph >= edge_pos[l];
        auto270[l] = ph <= edge_pos[l];
      end
    end
  end

  // expected search result from the stepping rules: done when all lanes on edge, any late steps down, else up
  function automatic void ref_search(output int stat, output int pc, output int steps, output int p90);
    int p, hits, dir;
    bit all_on, any_late;
    p = 0; hits = 0; stat = 0; steps = 0; p90 = 0;
    for (int it = 0; it < 1000 && stat == 0; it++) begin
      all_on = 1'b1;
      any_late = 1'b0;
      for (int l = 0; l < NL; l++) begin
        all_on &= (p == edge_pos[l]);
        any_late |= (p > edge_pos[l]);
      end
      dir = any_late ? -1 : 1;
      if (all_on) stat = 1;
      else if (p >= LIM || p <= -LIM) begin
`ifdef SDRAM_PHASE_AUTO90_EN
        if (hits == 0) begin
          hits = 1;
          p90 = (p90 + (dir > 0 ? 1 : 3)) % 4;
          p = 0;
        end else stat = 2;
`else
        stat = 2;
`endif
      end else begin
        p += dir;
        steps++;
      end
    end
    pc = p;
  endfunction

  task automatic run_auto(input string nm, input int es, input int epc, input int est, input int ep9, input int maxc, output int cyc);
    cyc = 0;
    wr(5'h0F);
    tick(4);
    n_en = 0;
    env_on = 1'b1;
    wr(5'h10);
    while (bus.cal_busy && cyc < maxc) begin
      tick();
      cyc++;
    end
    chk({nm, "_busy_end"}, bus.cal_busy, 0);
    chk({nm, "_stat"}, bus.cal_stat, es);
    chk({nm, "_pc"}, $signed(bus.phase_cnt), epc);
    chk({nm, "_steps"}, n_en, est);
    chk({nm, "_p90"}, bus.phase90sel, ep9);
    env_on = 1'b0;
  endtask

  task automatic auto_case(input string nm, input int e0, input int e1, input int maxc);
    int s, pc, st, p9, cyc;
    edge_pos[0] = e0;
    edge_pos[1] = e1;
    ref_search(s, pc, st, p9);
    run_auto(nm, s, pc, st, p9, maxc, cyc);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.pre_wcmd = 1'b0;
    bus.wd = 5'd0;
    edge_pos[0] = 0;
    edge_pos[1] = 0;
    tv[0]  = '{5'h01, 1'b1, 1'b1, 8'h01, 2'd0};
    tv[1]  = '{5'h01, 1'b1, 1'b1, 8'h02, 2'd0};
    tv[2]  = '{5'h02, 1'b1, 1'b0, 8'h01, 2'd0};
    tv[3]  = '{5'h04, 1'b0, 1'b0, 8'h01, 2'd1};
    tv[4]  = '{5'h04, 1'b0, 1'b0, 8'h01, 2'd2};
    tv[5]  = '{5'h04, 1'b0, 1'b0, 8'h01, 2'd3};
    tv[6]  = '{5'h04, 1'b0, 1'b0, 8'h01, 2'd0};
    tv[7]  = '{5'h0C, 1'b0, 1'b0, 8'h01, 2'd0};
    tv[8]  = '{5'h08, 1'b0, 1'b0, 8'h01, 2'd3};
    tv[9]  = '{5'h0C, 1'b0, 1'b0, 8'h01, 2'd0};
    tv[10] = '{5'h06, 1'b1, 1'b0, 8'h00, 2'd1};
    tv[11] = '{5'h0A, 1'b1, 1'b0, 8'hFF, 2'd0};
    tv[12] = '{5'h00, 1'b0, 1'b0, 8'hFF, 2'd0};
    tv[13] = '{5'h05, 1'b1, 1'b1, 8'h00, 2'd1};
    tick(3);
    rst = 1'b0;
    chk("rst_dcm", {bus.dcm_rst, bus.dcm_en, bus.dcm_incdec}, 0);
    chk("rst_phase", {bus.phase90sel, bus.phase_cnt}, 0);
    chk("rst_flags", {bus.ph_err, bus.lane_err}, 0);
    chk("rst_cal", {bus.cal_busy, bus.cal_stat}, 0);
    for (int i = 0; i < 14; i++) begin
      wr(tv[i].wd);
      chk($sformatf("vec%0d_en", i), bus.dcm_en, tv[i].en);
      if (tv[i].en) chk($sformatf("vec%0d_incdec", i), bus.dcm_incdec, tv[i].inc);
      chk($sformatf("vec%0d_pc", i), bus.phase_cnt, tv[i].pc);
      chk($sformatf("vec%0d_p90", i), bus.phase90sel, tv[i].p90);
      tick();
      chk($sformatf("vec%0d_en_pulse", i), bus.dcm_en, 0);
    end
    wr(5'h01);
    wr(5'h03);
    chk("dcmrst_c1", bus.dcm_rst, 1);
    chk("dcmrst_pc", bus.phase_cnt, 0);
    tick();
    chk("dcmrst_c2", bus.dcm_rst, 1);
    tick();
    chk("dcmrst_c3", bus.dcm_rst, 1);
    tick();
    chk("dcmrst_c4", bus.dcm_rst, 0);
    repeat (130) wr(5'h01);
    chk("sat_hi", bus.phase_cnt, 8'h7F);
    repeat (260) wr(5'h02);
    chk("sat_lo", bus.phase_cnt, 8'h80);
    wr(5'h0F);
    tick(4);
    man_enrd = 1'b1; man90 = 2'b11; man270 = 2'b11;
    tick();
    man_enrd = 1'b0;
    chk("flag_both_lane", bus.lane_err, 4'b1111);
    chk("flag_both_ph", bus.ph_err, 2'd3);
    wr(5'h00);
    chk("flag_clr_lane", bus.lane_err, 0);
    chk("flag_clr_ph", bus.ph_err, 0);
    man_enrd = 1'b1; man90 = 2'b01; man270 = 2'b00;
    wr(5'h00);
    man_enrd = 1'b0;
    chk("flag_clr_wins", bus.lane_err, 0);
    man_enrd = 1'b1;
    tick();
    man_enrd = 1'b0;
    chk("flag_mix_lane", bus.lane_err, 4'b1101);
    chk("flag_mix_ph", bus.ph_err, 2'd3);
    wr(5'h00);
    man_enrd = 1'b1; man90 = 2'b00; man270 = 2'b11;
    tick();
    man_enrd = 1'b0;
    chk("flag_early_lane", bus.lane_err, 4'b1010);
    chk("flag_early_ph", bus.ph_err, 2'd2);
    wr(5'h00);
    man_enrd = 1'b1; man90 = 2'b11; man270 = 2'b00;
    tick();
    man_enrd = 1'b0;
    chk("flag_late_lane", bus.lane_err, 4'b0101);
    chk("flag_late_ph", bus.ph_err, 2'd1);
    wr(5'h00);
    auto_case("t4_edge5", 5, 5, 3000);
    auto_case("t5_late", -100, -100, 30000);
    auto_case("disagree", -100, 100, 30000);
    for (int r = 0; r < 5; r++) begin
      int e;
      e = int'($urandom_range(0, 24)) - 12;
      auto_case($sformatf("rand%0d", r), e, e, 5000);
    end
    no_reads = 1'b1;
    edge_pos[0] = 5;
    edge_pos[1] = 5;
    run_auto("t6_noreads", 3, 0, 0, 0, 6000, cyc);
    chk("t6_tmo_len", (cyc >= 4094 && cyc <= 4100), 1);
    no_reads = 1'b0;
    hold_done = 1'b1;
    run_auto("t6_nodone", 3, 1, 1, 0, 6000, cyc);
    hold_done = 1'b0;
    tick(10);
    wr(5'h0F);
    tick(4);
    env_on = 1'b1;
    wr(5'h10);
    tick(150);
    chk("abort_busy_pre", bus.cal_busy, 1);
    wr(5'h01);
    chk("abort_busy", bus.cal_busy, 0);
    chk("abort_stat", bus.cal_stat, 0);
    chk("abort_en", bus.dcm_en, 1);
    chk("abort_incdec", bus.dcm_incdec, 1);
    tick(10);
    wr(5'h0F);
    tick(4);
    wr(5'h10);
    tick(300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", bus.cal_busy, 0);
    chk("midrst_en", bus.dcm_en, 0);
    chk("midrst_pc", bus.phase_cnt, 0);
    tick(10);
    chk("midrst_idle", bus.cal_busy, 0);
    env_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
